// File: rtl/nand_program_pins.sv
// nand_program_pins: registered NAND pin driver, progress counters and host data FIFO for the program FSM.
// Optional build macro PRGM_CHECKSUM_EN adds a running 16-bit sum of popped program bytes.
module nand_program_pins #(
  parameter int PACKET_LENGTH = 1024,
  parameter int ADDR_CYCLES   = 5,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_program,
  input  logic        cmd_prgm,
  input  logic        cmd_prgm_2,
  input  logic        cmd_rd_st,
  input  logic        cmd_write,
  input  logic        add_latch,
  input  logic        add_write_en,
  input  logic        prgm_data_latch,
  input  logic        prgm_data_en,
  input  logic [39:0] addr_in,
  input  logic        addr_load,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic        cle,
  output logic        ale,
  output logic        we_n,
  output logic        ce_n,
  output logic [7:0]  dq_out,
  output logic        dq_oe,
  output logic [1:0]  cmd_cnt,
  output logic [2:0]  counter_add,
  output logic [10:0] packet_count,
  output logic        underflow,
  output logic [15:0] prgm_checksum
);

  localparam int                PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [2:0]        ADDR_MAX  = 3'(ADDR_CYCLES);
  localparam logic [10:0]       PKT_MAX   = 11'(PACKET_LENGTH);
  localparam logic [PTR_W:0]    FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [7:0]        OP_PRGM   = 8'h80;
  localparam logic [7:0]        OP_PRGM_2 = 8'h10;
  localparam logic [7:0]        OP_RD_ST  = 8'h70;

  typedef enum logic [2:0] {
    ACT_IDLE,
    ACT_OPCODE,
    ACT_CMD_WR,
    ACT_ADDR_LATCH,
    ACT_ADDR_WR,
    ACT_DATA_LATCH,
    ACT_DATA_WR
  } action_e;

  action_e          action;
  logic [7:0]       op_sel;
  logic [7:0]       opcode;
  logic [39:0]      addr_sh;
  logic [7:0]       addr_byte;
  logic             addr_done;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   fifo_count;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;
  logic [7:0]       fifo_head;

  // One winning action per cycle; start_program suppresses every strobe.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    action = ACT_IDLE;
    op_sel = OP_RD_ST;
    if (start_program) begin
      action = ACT_IDLE;
    end else if (cmd_prgm | cmd_prgm_2 | cmd_rd_st) begin
      action = ACT_OPCODE;
      if (cmd_prgm)        op_sel = OP_PRGM;
      else if (cmd_prgm_2) op_sel = OP_PRGM_2;
    end else if (cmd_write) begin
      action = ACT_CMD_WR;
    end else if (add_write_en) begin
      action = ACT_ADDR_WR;
    end else if (add_latch) begin
      action = ACT_ADDR_LATCH;
    end else if (prgm_data_en) begin
      action = ACT_DATA_WR;
    end else if (prgm_data_latch) begin
      action = ACT_DATA_LATCH;
    end
  end

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == FIFO_FULL);
  assign wr_ready   = ~fifo_full;
  assign push       = wr_valid & ~fifo_full;
  assign pop        = (action == ACT_DATA_WR) & ~fifo_empty;
  // An empty FIFO presents 0xFF so the bus never carries stale storage.
  assign fifo_head  = fifo_empty ? 8'hFF : fifo_mem[rd_ptr];

  assign addr_done  = (counter_add >= ADDR_MAX);
  assign addr_byte  = addr_done ? 8'h00 : addr_sh[7:0];

  // NOTE: the storage array is deliberately not reset; pointers and occupancy define its contents.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
    end
  end

  // Address shifter: a load wins over a same-cycle shift.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_sh <= '0;
    end else if (addr_load) begin
      addr_sh <= addr_in;
    end else if (action == ACT_ADDR_WR && !addr_done) begin
      addr_sh <= {8'h00, addr_sh[39:8]};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      opcode <= 8'h00;
    end else if (action == ACT_OPCODE) begin
      opcode <= op_sel;
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      cle    <= 1'b0;
      ale    <= 1'b0;
      we_n   <= 1'b1;
      dq_oe  <= 1'b0;
      dq_out <= 8'h00;
    end else begin
      cle   <= 1'b0;
      ale   <= 1'b0;
      we_n  <= 1'b1;
      dq_oe <= 1'b0;
      case (action)
        ACT_OPCODE:     begin cle <= 1'b1; dq_oe <= 1'b1; dq_out <= op_sel; end
        ACT_CMD_WR:     begin cle <= 1'b1; we_n <= 1'b0; dq_oe <= 1'b1; dq_out <= opcode; end
        ACT_ADDR_LATCH: begin ale <= 1'b1; dq_oe <= 1'b1; dq_out <= addr_byte; end
        ACT_ADDR_WR:    begin ale <= 1'b1; we_n <= 1'b0; dq_oe <= 1'b1; dq_out <= addr_byte; end
        ACT_DATA_LATCH: begin dq_oe <= 1'b1; dq_out <= fifo_head; end
        ACT_DATA_WR:    begin we_n <= 1'b0; dq_oe <= 1'b1; dq_out <= fifo_head; end
        default:        ;
      endcase
    end
  end

  // Session state: chip enable and the progress counters the FSM consumes.
  always_ff @(posedge clock) begin
    if (reset) begin
      ce_n         <= 1'b1;
      cmd_cnt      <= 2'd0;
      counter_add  <= 3'd0;
      packet_count <= 11'd0;
      underflow    <= 1'b0;
    end else if (start_program) begin
      ce_n         <= 1'b0;
      cmd_cnt      <= 2'd0;
      counter_add  <= 3'd0;
      packet_count <= 11'd0;
      underflow    <= 1'b0;
    end else begin
      if (action == ACT_CMD_WR) begin
        if (cmd_cnt == 2'd3) ce_n <= 1'b1;
        else                 cmd_cnt <= cmd_cnt + 1'b1;
      end
      if (action == ACT_ADDR_WR && !addr_done) counter_add <= counter_add + 1'b1;
      if (pop && packet_count < PKT_MAX)       packet_count <= packet_count + 1'b1;
      if (action == ACT_DATA_WR && fifo_empty) underflow <= 1'b1;
    end
  end

`ifdef PRGM_CHECKSUM_EN
  logic [15:0] checksum_q;

  always_ff @(posedge clock) begin
    if (reset || start_program) begin
      checksum_q <= 16'h0000;
    end else if (pop) begin
      checksum_q <= checksum_q + {8'h00, fifo_head};
    end
  end

  assign prgm_checksum = checksum_q;
`else
  assign prgm_checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_nand_program_pins.sv
// tb_nand_program_pins: directed plus randomized stimulus checked cycle by cycle against a queue-based model.
// Build with PRGM_CHECKSUM_EN defined to also check the popped-byte checksum.
module tb_nand_program_pins;

  localparam int PACKET_LENGTH = 1024;
  localparam int ADDR_CYCLES   = 5;
  localparam int FIFO_DEPTH    = 16;

  logic        clock;
  logic        reset;
  logic        start_program;
  logic        cmd_prgm, cmd_prgm_2, cmd_rd_st, cmd_write;
  logic        add_latch, add_write_en, prgm_data_latch, prgm_data_en;
  logic [39:0] addr_in;
  logic        addr_load;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic        cle, ale, we_n, ce_n, dq_oe, underflow;
  logic [7:0]  dq_out;
  logic [1:0]  cmd_cnt;
  logic [2:0]  counter_add;
  logic [10:0] packet_count;
  logic [15:0] prgm_checksum;

  nand_program_pins #(
    .PACKET_LENGTH(PACKET_LENGTH),
    .ADDR_CYCLES  (ADDR_CYCLES),
    .FIFO_DEPTH   (FIFO_DEPTH)
  ) dut (
    .clock(clock), .reset(reset), .start_program(start_program),
    .cmd_prgm(cmd_prgm), .cmd_prgm_2(cmd_prgm_2), .cmd_rd_st(cmd_rd_st),
    .cmd_write(cmd_write), .add_latch(add_latch), .add_write_en(add_write_en),
    .prgm_data_latch(prgm_data_latch), .prgm_data_en(prgm_data_en),
    .addr_in(addr_in), .addr_load(addr_load), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .cle(cle), .ale(ale), .we_n(we_n), .ce_n(ce_n),
    .dq_out(dq_out), .dq_oe(dq_oe), .cmd_cnt(cmd_cnt), .counter_add(counter_add),
    .packet_count(packet_count), .underflow(underflow), .prgm_checksum(prgm_checksum)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: session state as plain numbers, FIFO and remaining address bytes as queues.
  logic [7:0] fq[$];
  logic [7:0] aq[$];
  logic [7:0] m_op, m_dq;
  bit         m_cle, m_ale, m_we_n, m_ce_n, m_oe, m_und;
  int         m_cmd, m_addr, m_pkt, m_sum;

  task automatic model_reset();
    fq.delete();
    aq.delete();
    m_op = 8'h00; m_dq = 8'h00;
    m_cle = 0; m_ale = 0; m_we_n = 1; m_ce_n = 1; m_oe = 0; m_und = 0;
    m_cmd = 0; m_addr = 0; m_pkt = 0; m_sum = 0;
  endtask

  function automatic logic [7:0] cur_addr_byte();
    if (m_addr >= ADDR_CYCLES || aq.size() == 0) return 8'h00;
    return aq[0];
  endfunction

  task automatic model_update();
    bit can_push;
    logic [7:0] b;
    if (reset) begin
      model_reset();
      return;
    end
    can_push = wr_valid && (fq.size() < FIFO_DEPTH);
    m_cle = 0; m_ale = 0; m_we_n = 1; m_oe = 0;
    if (start_program) begin
      m_ce_n = 0; m_cmd = 0; m_addr = 0; m_pkt = 0; m_und = 0; m_sum = 0;
    end else if (cmd_prgm || cmd_prgm_2 || cmd_rd_st) begin
      m_op  = cmd_prgm ? 8'h80 : (cmd_prgm_2 ? 8'h10 : 8'h70);
      m_cle = 1; m_oe = 1; m_dq = m_op;
    end else if (cmd_write) begin
      m_cle = 1; m_we_n = 0; m_oe = 1; m_dq = m_op;
      if (m_cmd == 3) m_ce_n = 1;
      else            m_cmd++;
    end else if (add_write_en || add_latch) begin
      m_ale = 1; m_oe = 1; m_we_n = !add_write_en; m_dq = cur_addr_byte();
      if (add_write_en && m_addr < ADDR_CYCLES) begin
        m_addr++;
        if (aq.size() > 0) aq.delete(0);
      end
    end else if (prgm_data_en) begin
      m_we_n = 0; m_oe = 1;
      if (fq.size() > 0) begin
        b = fq.pop_front();
        m_dq = b;
        if (m_pkt < PACKET_LENGTH) m_pkt++;
        m_sum = (m_sum + int'(b)) % 65536;
      end else begin
        m_dq = 8'hFF;
        m_und = 1;
      end
    end else if (prgm_data_latch) begin
      m_oe = 1;
      m_dq = (fq.size() > 0) ? fq[0] : 8'hFF;
    end
    if (addr_load) begin
      aq.delete();
      for (int i = 0; i < 5; i++) aq.push_back(addr_in[8*i +: 8]);
    end
    if (can_push) fq.push_back(wr_data);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    reset = 0; start_program = 0;
    cmd_prgm = 0; cmd_prgm_2 = 0; cmd_rd_st = 0; cmd_write = 0;
    add_latch = 0; add_write_en = 0; prgm_data_latch = 0; prgm_data_en = 0;
    addr_load = 0; wr_valid = 0;
  endtask

  // Inputs are set at a negedge; one clock is applied and every output is compared at the next negedge.
  task automatic tick(input string tag);
    logic [15:0] exp_sum;
    model_update();
    @(posedge clock);
    @(negedge clock);
`ifdef PRGM_CHECKSUM_EN
    exp_sum = 16'(m_sum);
`else
    exp_sum = 16'h0000;
`endif
    chk({tag, ".cle"},          32'(cle),          32'(m_cle));
    chk({tag, ".ale"},          32'(ale),          32'(m_ale));
    chk({tag, ".we_n"},         32'(we_n),         32'(m_we_n));
    chk({tag, ".ce_n"},         32'(ce_n),         32'(m_ce_n));
    chk({tag, ".dq_oe"},        32'(dq_oe),        32'(m_oe));
    chk({tag, ".dq_out"},       32'(dq_out),       32'(m_dq));
    chk({tag, ".wr_ready"},     32'(wr_ready),     32'(fq.size() < FIFO_DEPTH));
    chk({tag, ".cmd_cnt"},      32'(cmd_cnt),      32'(m_cmd));
    chk({tag, ".counter_add"},  32'(counter_add),  32'(m_addr));
    chk({tag, ".packet_count"}, 32'(packet_count), 32'(m_pkt));
    chk({tag, ".underflow"},    32'(underflow),    32'(m_und));
    chk({tag, ".checksum"},     32'(prgm_checksum), 32'(exp_sum));
    clear_inputs();
  endtask

  initial begin
    int sel;
    clear_inputs();
    addr_in = '0;
    wr_data = '0;
    model_reset();
    reset = 1;
    @(negedge clock);
    tick("reset");

    start_program = 1; tick("start");
    cmd_prgm = 1;      tick("op80");
    cmd_write = 1;     tick("cmdwr1");

    addr_load = 1; addr_in = 40'h04_03_02_01_00; tick("aload");
    for (int i = 0; i < 6; i++) begin
      add_latch = 1;    tick($sformatf("alat%0d", i));
      add_write_en = 1; tick($sformatf("awr%0d", i));
    end

    for (int i = 0; i < 16; i++) begin
      wr_valid = 1; wr_data = 8'hA0 + 8'(i); tick($sformatf("push%0d", i));
    end
    for (int i = 0; i < 17; i++) begin
      prgm_data_latch = 1; tick($sformatf("dlat%0d", i));
      prgm_data_en = 1;    tick($sformatf("den%0d", i));
    end

    // Full FIFO with a same-cycle push and pop: only the pop takes effect.
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1; wr_data = 8'($urandom); tick("fill");
    end
    wr_valid = 1; wr_data = 8'($urandom); prgm_data_en = 1; tick("full_pushpop");
    wr_valid = 1; wr_data = 8'($urandom); tick("refill");
    for (int i = 0; i < 16; i++) begin
      prgm_data_en = 1; tick("drain");
    end

    for (int i = 0; i < 3; i++) begin
      cmd_write = 1; tick($sformatf("cmdwr_sat%0d", i));
    end

    // Checksum carry case: 0xFF + 0xFF + 0x02 = 0x0200.
    start_program = 1; tick("start2");
    wr_valid = 1; wr_data = 8'hFF; tick("ck_push0");
    wr_valid = 1; wr_data = 8'hFF; tick("ck_push1");
    wr_valid = 1; wr_data = 8'h02; tick("ck_push2");
    for (int i = 0; i < 3; i++) begin
      prgm_data_en = 1; tick("ck_pop");
    end
    start_program = 1; tick("ck_clear");

    // Continuous stream drives packet_count to saturation.
    for (int i = 0; i < 1040; i++) begin
      wr_valid = 1; wr_data = 8'($urandom); prgm_data_en = 1; tick("stream");
    end

    cmd_rd_st = 1; tick("op70");
    for (int i = 0; i < 400; i++) begin
      start_program = ($urandom_range(0, 99) < 3);
      sel = $urandom_range(0, 11);
      cmd_prgm   = (sel == 0);
      cmd_prgm_2 = (sel == 1);
      cmd_rd_st  = (sel == 2);
      cmd_write  = ($urandom_range(0, 9) == 0);
      sel = $urandom_range(0, 5);
      add_latch    = (sel == 0);
      add_write_en = (sel == 1);
      sel = $urandom_range(0, 3);
      prgm_data_latch = (sel == 0);
      prgm_data_en    = (sel == 1);
      wr_valid  = $urandom_range(0, 1) == 1;
      wr_data   = 8'($urandom);
      addr_load = ($urandom_range(0, 19) == 0);
      addr_in   = {8'($urandom), 32'($urandom)};
      tick("rand");
    end

    // Reset overrides strobes on the same edge.
    wr_valid = 1; prgm_data_en = 1; cmd_write = 1; start_program = 1; reset = 1;
    tick("midreset");
    start_program = 1; tick("start3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
